// File: rtl/mmio_uart_tx.sv
// MMIO transmit-only UART: 16-byte register window feeding a byte FIFO and an 8N1 serializer.
// Optional even-parity bit (8E1) when UART_TX_PARITY_EN is defined; register writes are never stalled, overflowing pushes are dropped.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   div_lat_q, div_lat_d;
    logic [15:0]   timer_q, timer_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic       sel;
    logic [1:0] off;
    logic       wr_tx, wr_st, wr_div;
    logic       full, empty, push, pop, busy;
    logic       unused_bits;

    assign sel         = (A[31:4] == BASE_ADDR[31:4]);
    assign off         = A[3:2];
    assign wr_tx       = WE && sel && (off == 2'd0);
    assign wr_st       = WE && sel && (off == 2'd1);
    assign wr_div      = WE && sel && (off == 2'd2);
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign push        = wr_tx && !full;
    assign busy        = (state_q != S_IDLE);
    assign irq         = empty && !busy;
    assign unused_bits = ^{WD[31:16], A[1:0]};

    always_comb begin
        RD = 32'd0;
        if (sel) begin
            unique case (off)
                2'd1:    RD = {23'd0, 5'(count_q), ovf_q, busy, empty, full};
                2'd2:    RD = {16'd0, div_q};
                default: RD = 32'd0;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_div) div_d = (WD[15:0] == 16'd0) ? 16'd1 : WD[15:0];
        if (wr_st && WD[3]) ovf_d = 1'b0;
        if (wr_tx && full) ovf_d = 1'b1;
    end

    // Every state lasts div_lat cycles: the timer is reloaded with div_lat-1 on entry.
    always_comb begin
        state_d   = state_q;
        div_lat_d = div_lat_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    state_d   = S_DATA;
                    timer_d   = div_lat_q - 16'd1;
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = div_lat_q - 16'd1;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_q == 16'd0) begin
                    state_d = S_STOP;
                    timer_d = div_lat_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == 16'd0) begin
                    if (!empty) pop = 1'b1;
                    else state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame start: the divisor is frozen here so mid-frame DIV writes only affect later frames.
        if (pop) begin
            state_d   = S_START;
            div_lat_d = div_q;
            timer_d   = div_q - 16'd1;
            shift_d   = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d     = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= WD[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            div_q     <= CLK_DIV;
            div_lat_q <= CLK_DIV;
            timer_q   <= 16'd0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, word-aligned base of the 16-byte register window.
REQ-002 Parameter CLK_DIV, default 16'd868, reset value of the baud divisor (cycles per bit).
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, 2..16, TX FIFO entries.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 WE  input  1  data-bus write enable from the core.
REQ-007 A  input  32  data-bus byte address from the core.
REQ-008 WD  input  32  data-bus write data.
REQ-009 RD  output  32  data-bus read data, combinational from A.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 irq  output  1  high while the FIFO is empty and the FSM is IDLE (transmit-done level).

Function
REQ-012 Select = (A[31:4] == BASE_ADDR[31:4]); A[1:0] ignored; offset = A[3:2].
REQ-013 Not selected: RD = 0, writes ignored.
REQ-014 Offset 0 TXDATA: write pushes WD[7:0]; read returns 0.
REQ-015 Offset 1 STATUS, read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[8:4] FIFO count, others 0.
REQ-016 STATUS write with WD[3]=1 clears overflow; other bits read-only.
REQ-017 Offset 2 DIV: R/W, bits[15:0]; a written value of 0 is stored as 1; bits[31:16] read 0.
REQ-018 Offset 3: reads 0, writes ignored.
REQ-019 Write occurs at the rising edge where WE=1 and the address is selected; RD is valid in the same cycle as A (single-cycle core timing).
REQ-020 Push when full (full evaluated before any same-cycle pop): data dropped, overflow set at that edge.
REQ-021 FSM states IDLE, START, DATA, STOP (plus PARITY, see REQ-030).
REQ-022 IDLE with FIFO non-empty: pop at the edge, go to START, latch DIV into the bit timer for the whole frame.
REQ-023 Each state holds tx for exactly latched-DIV cycles; START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
REQ-024 After STOP: pop the next byte and go to START if the FIFO is non-empty, else go to IDLE; there is no idle gap between back-to-back frames.
REQ-025 Latency: a TXDATA write at edge k into an empty FIFO with the FSM in IDLE gives tx=0 from edge k+1.
REQ-026 A DIV write mid-frame takes effect from the next frame only.
REQ-027 A simultaneous push and pop on a non-full FIFO is accepted; the count is unchanged.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-029 reset low asynchronously forces: FSM IDLE, tx=1, FIFO empty (count 0, pointers 0), overflow 0, DIV=CLK_DIV, bit timer 0, irq=1, RD as decoded; a frame in flight is abandoned without completing.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP drives the even parity of the 8 data bits for DIV cycles; frame is 11 bits.
REQ-031 UART_TX_PARITY_EN undefined: no PARITY state; 8N1, 10-bit frame.

Verification
REQ-032 DIV=4, write 0x55 to TXDATA -> tx low from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; irq returns to 1; 40 cycles total (44 with parity, parity bit 0).
REQ-033 Nine writes 0x01..0x09 in consecutive cycles with DIV=8 -> first byte popped immediately, all eight others stored; STATUS.full=1, overflow=0; all 9 bytes transmitted back-to-back.
REQ-034 Ten consecutive writes -> tenth dropped, STATUS bit3=1; STATUS write 0x8 -> bit3=0.
REQ-035 Write DIV=0 -> DIV reads 1; write DIV=6 mid-frame -> current frame keeps old timing, next frame uses 6.
REQ-036 reset pulsed low mid-DATA -> tx=1 immediately, STATUS reads 0x2, DIV reads CLK_DIV.
REQ-037 Read A=BASE_ADDR+0x10 and write there -> RD=0 and no state change.
